// File: rtl/image_pad_loader_if.sv
// Pixel stream in, padded image out, plus the image handshake.
interface image_pad_loader_if #(
  parameter int BITWIDTH = 32,
  parameter int IMG_H    = 28,
  parameter int IMG_W    = 28,
  parameter int PAD      = 2
);
  localparam int PH = IMG_H + 2 * PAD;
  localparam int PW = IMG_W + 2 * PAD;

  logic signed [BITWIDTH-1:0] pix_in;
  logic                       pix_valid;
  logic                       pix_sof;
  logic                       pix_ready;
  logic signed [BITWIDTH-1:0] image_padded [PH][PW];
  logic                       image_valid;
  logic                       image_ack;
  logic                       frame_err;

  modport master (
    output pix_in, pix_valid, pix_sof, image_ack,
    input  pix_ready, image_padded, image_valid, frame_err
  );

  modport slave (
    input  pix_in, pix_valid, pix_sof, image_ack,
    output pix_ready, image_padded, image_valid, frame_err
  );
endinterface

// File: rtl/image_pad_loader.sv
// Loads a raster pixel stream into the interior of a zero-bordered image and
// holds the finished frame until the consumer acknowledges it.
//
// state | meaning
// LOAD  | accepting pixels; image_padded shows the partial frame
// FULL  | frame complete, image_valid high, input stalled until image_ack
module image_pad_loader #(
  parameter int BITWIDTH = 32,
  parameter int IMG_H    = 28,
  parameter int IMG_W    = 28,
  parameter int PAD      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  image_pad_loader_if.slave    bus
);
  localparam int PH = IMG_H + 2 * PAD;
  localparam int PW = IMG_W + 2 * PAD;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  typedef enum logic {LOAD = 1'b0, FULL = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [RW-1:0]              row_q, row_d;
  logic [CW-1:0]              col_q, col_d;
  logic                       frame_err_q, frame_err_d;
  logic                       wr_en;
  logic [RW-1:0]              wr_row;
  logic [CW-1:0]              wr_col;
  logic                       xfer;
  logic signed [BITWIDTH-1:0] interior_q [IMG_H][IMG_W];

  // Ready depends on state alone, so there is no combinational path from the inputs.
  assign bus.pix_ready   = (state_q == LOAD);
  assign bus.image_valid = (state_q == FULL);
  assign bus.frame_err   = frame_err_q;
  assign xfer            = bus.pix_valid && (state_q == LOAD);

  // Next-state, raster counters and write address.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;
    wr_row      = row_q;
    wr_col      = col_q;
    case (state_q)
      LOAD: begin
        if (xfer) begin
          wr_en = 1'b1;
          if (bus.pix_sof && ((row_q != '0) || (col_q != '0))) begin
            // Restart: this pixel becomes the first of a new frame.
            wr_row      = '0;
            wr_col      = '0;
            row_d       = '0;
            col_d       = CW'(1);
            frame_err_d = 1'b1;
          end else if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
            state_d = FULL;
            row_d   = '0;
            col_d   = '0;
          end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (bus.image_ack) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      row_q       <= '0;
      col_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Interior pixel storage; the border has none.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      interior_q <= '{default: '0};
    end else if (wr_en) begin
      interior_q[wr_row][wr_col] <= bus.pix_in;
    end
  end

  for (genvar r = 0; r < PH; r++) begin : g_row
    for (genvar c = 0; c < PW; c++) begin : g_col
      if ((r < PAD) || (r >= IMG_H + PAD) || (c < PAD) || (c >= IMG_W + PAD)) begin : g_border
        assign bus.image_padded[r][c] = '0;
      end else begin : g_cell
        assign bus.image_padded[r][c] = interior_q[r-PAD][c-PAD];
      end
    end
  end
endmodule

// File: tb/tb_image_pad_loader.sv
// Scoreboard bench for image_pad_loader: a shadow model of the interior is
// updated per accepted pixel, and each completed frame is queued for checking.
module tb_image_pad_loader;
  localparam int BW = 32;
  localparam int H  = 28;
  localparam int W  = 28;
  localparam int P  = 2;
  localparam int PH = H + 2 * P;
  localparam int PW = W + 2 * P;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  image_pad_loader_if #(.BITWIDTH(BW), .IMG_H(H), .IMG_W(W), .PAD(P)) bus ();

  image_pad_loader #(.BITWIDTH(BW), .IMG_H(H), .IMG_W(W), .PAD(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int                 r;
    int                 c;
    logic signed [31:0] v;
  } exp_t;

  exp_t               sb_q [$];
  logic signed [31:0] m_img [H][W];
  int                 m_row, m_col;
  bit                 m_full;

  function automatic void model_clear();
    foreach (m_img[r, c]) m_img[r][c] = '0;
    m_row  = 0;
    m_col  = 0;
    m_full = 0;
  endfunction

  function automatic void push_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        sb_q.push_back('{r + P, c + P, m_img[r][c]});
  endfunction

  function automatic bit is_border(input int r, input int c);
    return (r < P) || (r >= H + P) || (c < P) || (c >= W + P);
  endfunction

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < PH; r++)
      for (int c = 0; c < PW; c++) begin
        checks++;
        if (bus.image_padded[r][c] !== 32'sd0) begin
          errors++;
          $display("FAIL %s cell[%0d][%0d] got %0d exp 0", tag, r, c, bus.image_padded[r][c]);
        end
      end
  endtask

  // Drives one pixel at posedge+1; the transfer happens on the next edge.
  task automatic send_pix(input logic signed [31:0] v, input bit sof, input bit gap);
    bit exp_err;
    exp_err = 0;
    if (gap) begin
      int n = 0;
      while (($urandom_range(0, 1) == 1) && (n < 8)) begin
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b1;
        bus.pix_in    = $urandom;
        @(posedge clk); #1;
        n++;
      end
    end
    bus.pix_in    = v;
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    checks++;
    if (bus.pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL pix_ready_load got %b exp 1", bus.pix_ready);
    end
    @(posedge clk); #1;
    if (sof && ((m_row != 0) || (m_col != 0))) begin
      m_img[0][0] = v;
      m_row       = 0;
      m_col       = 1;
      exp_err     = 1;
    end else begin
      m_img[m_row][m_col] = v;
      if ((m_row == H - 1) && (m_col == W - 1)) begin
        m_row  = 0;
        m_col  = 0;
        m_full = 1;
        push_frame();
      end else if (m_col == W - 1) begin
        m_col = 0;
        m_row++;
      end else begin
        m_col++;
      end
    end
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    checks++;
    if (bus.frame_err !== exp_err) begin
      errors++;
      $display("FAIL frame_err got %b exp %b", bus.frame_err, exp_err);
    end
    checks++;
    if (bus.image_valid !== m_full) begin
      errors++;
      $display("FAIL image_valid got %b exp %b", bus.image_valid, m_full);
    end
  endtask

  // Pops the scoreboard against the presented image and checks the border.
  task automatic check_frame(input string tag);
    int n = 0;
    while ((bus.image_valid !== 1'b1) && (n < 10)) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.image_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s image_valid_wait got %b exp 1", tag, bus.image_valid);
    end
    checks++;
    if (sb_q.size() != H * W) begin
      errors++;
      $display("FAIL %s sb_size got %0d exp %0d", tag, sb_q.size(), H * W);
    end
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (bus.image_padded[e.r][e.c] !== e.v) begin
        errors++;
        $display("FAIL %s cell[%0d][%0d] got %0d exp %0d", tag, e.r, e.c,
                 bus.image_padded[e.r][e.c], e.v);
      end
    end
    for (int r = 0; r < PH; r++)
      for (int c = 0; c < PW; c++)
        if (is_border(r, c)) begin
          checks++;
          if (bus.image_padded[r][c] !== 32'sd0) begin
            errors++;
            $display("FAIL %s border[%0d][%0d] got %0d exp 0", tag, r, c, bus.image_padded[r][c]);
          end
        end
    checks++;
    if (bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s pix_ready_full got %b exp 0", tag, bus.pix_ready);
    end
  endtask

  task automatic do_ack();
    bus.image_ack = 1'b1;
    @(posedge clk); #1;
    bus.image_ack = 1'b0;
    bus.pix_valid = 1'b0;
    m_full        = 0;
    checks++;
    if (bus.image_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack image_valid got %b exp 0", bus.image_valid);
    end
    checks++;
    if (bus.pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL ack pix_ready got %b exp 1", bus.pix_ready);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.image_ack = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.image_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset image_valid got %b exp 0", bus.image_valid);
    end
    checks++;
    if (bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset frame_err got %b exp 0", bus.frame_err);
    end
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset pix_ready got %b exp 1", bus.pix_ready);
    end
  endtask

  task automatic test_full_frame();
    int pr [4] = '{2, 2, 3, 29};
    int pc [4] = '{2, 29, 2, 29};
    int pv [4] = '{1, 28, 29, 784};
    for (int k = 0; k < H * W; k++) send_pix(k + 1, k == 0, 0);
    check_frame("full");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.image_padded[pr[i]][pc[i]] !== pv[i]) begin
        errors++;
        $display("FAIL full_spot[%0d][%0d] got %0d exp %0d", pr[i], pc[i],
                 bus.image_padded[pr[i]][pc[i]], pv[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bus.pix_in    = 999;
    bus.pix_valid = 1'b1;
    bus.pix_sof   = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    bus.pix_sof = 1'b0;
    push_frame();
    check_frame("hold");
    do_ack();
    for (int k = 0; k < H * W; k++) send_pix(-5, 0, 0);
    check_frame("neg5");
  endtask

  task automatic test_restart();
    do_ack();
    for (int k = 0; k < 100; k++) send_pix(1000 + k, k == 0, 0);
    send_pix(7, 1, 0);
    checks++;
    if (bus.image_padded[P][P] !== 32'sd7) begin
      errors++;
      $display("FAIL restart cell[2][2] got %0d exp 7", bus.image_padded[P][P]);
    end
    for (int k = 0; k < H * W - 1; k++) send_pix(2000 + k, 0, 0);
    check_frame("restart");
  endtask

  task automatic test_gapped();
    do_ack();
    for (int k = 0; k < H * W; k++) send_pix(k + 1, k == 0, 1);
    check_frame("gapped");
  endtask

  task automatic test_mid_reset();
    do_ack();
    for (int k = 0; k < 500; k++) send_pix(k * 3 - 1000, k == 0, 0);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all_zero("midrst");
    checks++;
    if (bus.image_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst image_valid got %b exp 0", bus.image_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < H * W; k++) send_pix(-(k + 1) * 65536, 0, 0);
    check_frame("after_rst");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_restart();
    test_gapped();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
